wrp_slave_io: RTL
=================

Name: wrp_slave_io

Overview:
- AHB slave-side wrapper; the responder counterpart to the team's AHB master wrapper.
- Accepts single 32-bit AHB transfers from the bus/decoder and converts them into a simple level-request device interface (SRead/SWrite/SAddress/SWriteData/SReadData/SReady) for memories and peripherals.
- Inserts wait states until the device acknowledges.
- Returns an ERROR response for unsupported transfers or device timeout.

Parameters:
TIMEOUT, 16, max wait cycles for SReady in an access state before ERROR; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
HCLK  input  1  bus clock; all logic on its rising edge
HRESET  input  1  synchronous reset, active-high
HSEL  input  1  slave select from address decoder
HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  input  1  1=write, 0=read (address phase)
HSIZE  input  3  transfer size; only 3'b010 (32-bit) supported
HBURST  input  3  ignored
HPROT  input  4  ignored
HADDR  input  32  address phase address
HWDATA  input  32  write data, valid in data phase
HREADYIN  input  1  bus HREADY (previous transfer complete)
HREADYOUT  output  1  slave ready; 0 inserts wait state
HRESP  output  2  OKAY=00, ERROR=01
HRDATA  output  32  registered read data
SRead  output  1  device read request, level, held until SReady
SWrite  output  1  device write request, level, held until SReady
SAddress  output  32  registered transfer address
SWriteData  output  32  write data to device
SReadData  input  32  device read data, valid with SReady
SReady  input  1  device completion strobe

Behaviour:
- Valid address phase = HSEL && HREADYIN && HTRANS[1]. It is sampled only in IDLE, RDONE, WDONE and ERR2 (the states with HREADYOUT=1).
- On a valid address phase, register HADDR into SAddress.
- HSEL with HTRANS IDLE/BUSY: zero-wait OKAY, no device activity.
- States: IDLE, READ, RDONE, WRITE, WDONE, ERR1, ERR2.
- Sampling-state transitions on a valid address phase:
  - HSIZE!=010 or HADDR[1:0]!=00 -> ERR1.
  - Otherwise HWRITE=0 -> READ; HWRITE=1 -> WRITE.
  - No valid address phase -> IDLE.
- IDLE: HREADYOUT=1, HRESP=OKAY.
- READ:
  - SRead=1, HREADYOUT=0, HRESP=OKAY.
  - On SReady: HRDATA<=SReadData; next state RDONE.
- RDONE: HREADYOUT=1, HRESP=OKAY, HRDATA valid; SRead=0.
- WRITE:
  - SWrite=1, SWriteData=HWDATA (combinational; HWDATA is stable while HREADYOUT=0), HREADYOUT=0.
  - On SReady -> WDONE.
- WDONE: HREADYOUT=1, HRESP=OKAY; SWrite=0.
- SWriteData=0 outside WRITE.
- Timeout:
  - Counter clears on entry to READ/WRITE and increments each cycle SReady=0.
  - When TIMEOUT!=0 and the count reaches TIMEOUT-1 with SReady=0: drop SRead/SWrite the next cycle and go to ERR1. HRDATA is unchanged.
- ERR1: HREADYOUT=0, HRESP=ERROR.
- ERR2: HREADYOUT=1, HRESP=ERROR. Standard two-cycle ERROR response.
- Latency: read with SReady in the first READ cycle gives 1 wait state (data on HRDATA at cycle addr+2). Write is the same.
- SReady arriving in the same cycle the timeout expires: SReady wins (normal completion).
- SReady outside READ/WRITE: ignored.
- Back-to-back: a new address phase sampled in RDONE/WDONE/ERR2 goes directly to READ/WRITE/ERR1 with no IDLE bubble.
- Reset (any state, including mid-access):
  - Next state IDLE.
  - HREADYOUT=1, HRESP=00, HRDATA=0, SRead=0, SWrite=0, SAddress=0, SWriteData=0, counter=0.
  - Any outstanding device request is dropped at that edge.

Test Plan:
- Read at 0x0000_0040, device returns 0xDEAD_BEEF with SReady one cycle later -> SRead high 2 cycles, HREADYOUT low 2 cycles, HRDATA=0xDEADBEEF with HREADYOUT=1, HRESP=00.
- Write 0x1234_5678 to 0x0000_0100, SReady after 3 cycles -> SWrite high 3 cycles, SAddress=0x100, SWriteData=0x12345678, then HREADYOUT=1, OKAY.
- HSIZE=000 or HADDR=0x0000_0002 -> no SRead/SWrite; ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01).
- TIMEOUT=4, device never asserts SReady -> SRead high exactly 4 cycles, then two-cycle ERROR response; SReady at cycle 4 instead -> OKAY completion.
- Read then write back-to-back, second address phase in RDONE -> WRITE entered next cycle, no IDLE cycle; HTRANS=BUSY with HSEL=1 -> zero-wait OKAY, no request.
- Assert HRESET during WRITE wait -> next cycle SWrite=0, HREADYOUT=1, HRESP=00, all outputs at reset values; next valid transfer completes normally.

Source files
------------

// File: rtl/wrp_slave_io.sv
// AHB slave-side wrapper. Accepts single 32-bit AHB transfers and turns them
// into a level-request device interface (SRead/SWrite held until SReady).
// Wait states are inserted until the device acknowledges. Unsupported
// transfers and device timeouts produce the two-cycle AHB ERROR response.
module wrp_slave_io #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,
    output logic        SRead,
    output logic        SWrite,
    output logic [31:0] SAddress,
    output logic [31:0] SWriteData,
    input  logic [31:0] SReadData,
    input  logic        SReady
);

    localparam logic [1:0]       RESP_OKAY  = 2'b00;
    localparam logic [1:0]       RESP_ERROR = 2'b01;
    localparam logic [2:0]       SIZE_WORD  = 3'b010;
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam bit               TO_EN      = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_RDONE = 3'd2,
        ST_WRITE = 3'd3,
        ST_WDONE = 3'd4,
        ST_ERR1  = 3'd5,
        ST_ERR2  = 3'd6
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic addr_valid;
    logic bad_xfer;
    logic timeout_hit;
    logic unused_ok;

    // Burst/protection hints and the SEQ/NONSEQ distinction carry no meaning here.
    assign unused_ok   = ^{HBURST, HPROT, HTRANS[0]};

    assign addr_valid  = HSEL & HREADYIN & HTRANS[1];
    assign bad_xfer    = (HSIZE != SIZE_WORD) || (HADDR[1:0] != 2'b00);
    // Expiry only counts when the device stays silent in the last allowed cycle.
    assign timeout_hit = TO_EN && (cnt == CNT_LAST) && !SReady;

    // Write data is passed straight through while the device write is pending.
    assign SWriteData  = (state == ST_WRITE) ? HWDATA : 32'h0000_0000;

    // Transfer state machine with registered bus and device-side outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            cnt       <= CNT_ZERO;
            HREADYOUT <= 1'b1;
            HRESP     <= RESP_OKAY;
            HRDATA    <= 32'h0000_0000;
            SRead     <= 1'b0;
            SWrite    <= 1'b0;
            SAddress  <= 32'h0000_0000;
        end else begin
            case (state)
                // States that complete a transfer also accept the next address phase.
                ST_IDLE, ST_RDONE, ST_WDONE, ST_ERR2: begin
                    if (addr_valid) begin
                        SAddress <= HADDR;
                        cnt      <= CNT_ZERO;
                        if (bad_xfer) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= RESP_ERROR;
                            SRead     <= 1'b0;
                            SWrite    <= 1'b0;
                        end else if (HWRITE) begin
                            state     <= ST_WRITE;
                            HREADYOUT <= 1'b0;
                            HRESP     <= RESP_OKAY;
                            SRead     <= 1'b0;
                            SWrite    <= 1'b1;
                        end else begin
                            state     <= ST_READ;
                            HREADYOUT <= 1'b0;
                            HRESP     <= RESP_OKAY;
                            SRead     <= 1'b1;
                            SWrite    <= 1'b0;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= RESP_OKAY;
                        SRead     <= 1'b0;
                        SWrite    <= 1'b0;
                    end
                end

                ST_READ: begin
                    if (SReady) begin
                        state     <= ST_RDONE;
                        HRDATA    <= SReadData;
                        HREADYOUT <= 1'b1;
                        HRESP     <= RESP_OKAY;
                        SRead     <= 1'b0;
                    end else if (timeout_hit) begin
                        state     <= ST_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= RESP_ERROR;
                        SRead     <= 1'b0;
                    end else begin
                        cnt       <= cnt + CNT_ONE;
                    end
                end

                ST_WRITE: begin
                    if (SReady) begin
                        state     <= ST_WDONE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= RESP_OKAY;
                        SWrite    <= 1'b0;
                    end else if (timeout_hit) begin
                        state     <= ST_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= RESP_ERROR;
                        SWrite    <= 1'b0;
                    end else begin
                        cnt       <= cnt + CNT_ONE;
                    end
                end

                // First ERROR cycle stalls the bus; the second one releases it.
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= RESP_ERROR;
                    SRead     <= 1'b0;
                    SWrite    <= 1'b0;
                end

                default: begin
                    state     <= ST_IDLE;
                    cnt       <= CNT_ZERO;
                    HREADYOUT <= 1'b1;
                    HRESP     <= RESP_OKAY;
                    SRead     <= 1'b0;
                    SWrite    <= 1'b0;
                end
            endcase
        end
    end

endmodule
